// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: two-port arbiter in front of a single-port RAM.
// Grants are combinational, so a lone requester gets the RAM in the cycle it
// asks. On contention the two ports alternate under a 1-bit round-robin
// pointer. Responses (rvalid/rdata) come back exactly one cycle after the
// grant, which matches the RAM's one-cycle read latency.
// Optional build macro SP_RAM_ARB_FIXED_PRIO_EN: port 0 always wins
// contention and the design carries no round-robin pointer register.
module sp_ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [1:0]                          req_i,
    input  logic [1:0][ADDR_WIDTH-1:0]          addr_i,
    input  logic [1:0]                          we_i,
    input  logic [1:0][DATA_WIDTH/8-1:0]        be_i,
    input  logic [1:0][DATA_WIDTH-1:0]          wdata_i,
    output logic [1:0]                          gnt_o,
    output logic [1:0]                          rvalid_o,
    output logic [1:0][DATA_WIDTH-1:0]          rdata_o,
    output logic                                en_o,
    output logic [ADDR_WIDTH-1:0]               addr_o,
    output logic [DATA_WIDTH-1:0]               wdata_o,
    output logic                                we_o,
    output logic [DATA_WIDTH/8-1:0]             be_o,
    input  logic [DATA_WIDTH-1:0]               rdata_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [1:0] gnt_s;
    logic       prio_s;
    logic [1:0] rvalid_r;
    logic       resp_we_r;

`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    // Fixed priority: port 0 is always the preferred port on contention.
    assign prio_s = 1'b0;
`else
    logic prio_q;

    // Round-robin pointer: after each grant, point at the port that lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (gnt_s[0]) begin
            prio_q <= 1'b1;
        end else if (gnt_s[1]) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_q;
        end
    end

    assign prio_s = prio_q;
`endif

    // Grant decision: a lone requester wins at once, contention goes to prio_s.
    always_comb begin
        gnt_s = 2'b00;
        if (req_i == 2'b11) begin
            if (prio_s) begin
                gnt_s = 2'b10;
            end else begin
                gnt_s = 2'b01;
            end
        end else begin
            gnt_s = req_i;
        end
    end

    assign gnt_o = gnt_s;
    assign en_o  = req_i[0] | req_i[1];

    // RAM-side mux: forward the granted port's command, all zeros when idle.
    always_comb begin
        addr_o  = {ADDR_WIDTH{1'b0}};
        wdata_o = {DATA_WIDTH{1'b0}};
        we_o    = 1'b0;
        be_o    = {BE_WIDTH{1'b0}};
        if (gnt_s[0]) begin
            addr_o  = addr_i[0];
            wdata_o = wdata_i[0];
            we_o    = we_i[0];
            be_o    = be_i[0];
        end else if (gnt_s[1]) begin
            addr_o  = addr_i[1];
            wdata_o = wdata_i[1];
            we_o    = we_i[1];
            be_o    = be_i[1];
        end else begin
            addr_o  = {ADDR_WIDTH{1'b0}};
            wdata_o = {DATA_WIDTH{1'b0}};
            we_o    = 1'b0;
            be_o    = {BE_WIDTH{1'b0}};
        end
    end

    // Response register: remembers who was granted and whether it was a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_r  <= 2'b00;
            resp_we_r <= 1'b0;
        end else begin
            rvalid_r  <= gnt_s;
            resp_we_r <= we_o;
        end
    end

    assign rvalid_o = rvalid_r;

    // Read data steering: only the responding port of a read sees RAM data.
    always_comb begin
        rdata_o = {(2 * DATA_WIDTH){1'b0}};
        for (int p = 0; p < 2; p++) begin
            if (rvalid_r[p] && !resp_we_r) begin
                rdata_o[p] = rdata_i;
            end else begin
                rdata_o[p] = {DATA_WIDTH{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb_sp_ram_arbiter: directed bench for sp_ram_arbiter with a behavioural
// byte-enabled RAM (one-cycle read latency) attached to the RAM-side ports.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_sp_ram_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic                 clk;
    logic                 rst;
    logic [1:0]           req_i;
    logic [1:0][AW-1:0]   addr_i;
    logic [1:0]           we_i;
    logic [1:0][BW-1:0]   be_i;
    logic [1:0][DW-1:0]   wdata_i;
    logic [1:0]           gnt_o;
    logic [1:0]           rvalid_o;
    logic [1:0][DW-1:0]   rdata_o;
    logic                 en_o;
    logic [AW-1:0]        addr_o;
    logic [DW-1:0]        wdata_o;
    logic                 we_o;
    logic [BW-1:0]        be_o;
    logic [DW-1:0]        rdata_i;

    logic [DW-1:0] mem [0:(1 << AW) / BW - 1];

    int checks;
    int failures;

    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_i),
        .addr_i   (addr_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .wdata_i  (wdata_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .en_o     (en_o),
        .addr_o   (addr_o),
        .wdata_o  (wdata_o),
        .we_o     (we_o),
        .be_o     (be_o),
        .rdata_i  (rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: byte-masked writes, registered reads.
    always @(posedge clk) begin
        if (en_o) begin
            if (we_o) begin
                for (int b = 0; b < BW; b++) begin
                    if (be_o[b]) mem[addr_o / BW][8*b +: 8] <= wdata_o[8*b +: 8];
                end
            end else begin
                rdata_i <= mem[addr_o / BW];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req_i    = 2'b00;
        addr_i   = '0;
        we_i     = 2'b00;
        be_i     = '0;
        wdata_i  = '0;

        // Reset state; grant path stays combinational during reset.
        @(negedge clk); #1;
        chk("rst_rvalid", 64'(rvalid_o), 64'h0);
        chk("rst_rdata", 64'(rdata_o), 64'h0);
        chk("rst_gnt_idle", 64'(gnt_o), 64'h0);
        chk("rst_addr_idle", 64'(addr_o), 64'h0);
        req_i = 2'b10; addr_i[1] = 8'h44; #1;
        chk("rst_gnt_comb", 64'(gnt_o), 64'h2);
        chk("rst_en_comb", 64'(en_o), 64'h1);
        chk("rst_addr_comb", 64'(addr_o), 64'h44);
        req_i = 2'b00; addr_i[1] = 8'h00;
        @(negedge clk); rst = 1'b0;

        // Port 0 write 0xDEADBEEF to 0x10, then read it back.
        @(negedge clk);
        req_i = 2'b01; addr_i[0] = 8'h10; we_i[0] = 1'b1; be_i[0] = 4'hF; wdata_i[0] = 32'hDEADBEEF; #1;
        chk("wr_gnt", 64'(gnt_o), 64'h1);
        chk("wr_we_o", 64'(we_o), 64'h1);
        chk("wr_addr_o", 64'(addr_o), 64'h10);
        chk("wr_wdata_o", 64'(wdata_o), 64'hDEADBEEF);
        chk("wr_be_o", 64'(be_o), 64'hF);
        chk("wr_rvalid_pre", 64'(rvalid_o), 64'h0);
        @(negedge clk);
        we_i[0] = 1'b0; wdata_i[0] = 32'h0; #1;
        chk("rd_gnt_b2b", 64'(gnt_o), 64'h1);
        chk("wr_rvalid", 64'(rvalid_o), 64'h1);
        chk("wr_rdata_zero", 64'(rdata_o[0]), 64'h0);
        @(negedge clk);
        req_i = 2'b00; #1;
        chk("rd_rvalid", 64'(rvalid_o), 64'h1);
        chk("rd_rdata0", 64'(rdata_o[0]), 64'hDEADBEEF);
        chk("idle_gnt", 64'(gnt_o), 64'h0);
        chk("idle_en", 64'(en_o), 64'h0);
        chk("idle_addr", 64'(addr_o), 64'h0);
        chk("idle_wdata", 64'(wdata_o), 64'h0);
        chk("idle_be", 64'(be_o), 64'h0);
        @(negedge clk); #1;
        chk("rd_rvalid_single", 64'(rvalid_o), 64'h0);

        // Port 1 partial write: 0xFFFFFFFF, then 0x11223344 with be 0x3.
        @(negedge clk);
        req_i = 2'b10; addr_i[1] = 8'h20; we_i[1] = 1'b1; be_i[1] = 4'hF; wdata_i[1] = 32'hFFFFFFFF; #1;
        chk("pw_gnt", 64'(gnt_o), 64'h2);
        @(negedge clk);
        wdata_i[1] = 32'h11223344; be_i[1] = 4'h3; #1;
        chk("pw_be_o", 64'(be_o), 64'h3);
        chk("pw_wdata_o", 64'(wdata_o), 64'h11223344);
        chk("pw_rvalid", 64'(rvalid_o), 64'h2);
        chk("pw_rdata_zero", 64'(rdata_o[1]), 64'h0);
        @(negedge clk);
        we_i[1] = 1'b0; be_i[1] = 4'hF; #1;
        chk("pr_gnt", 64'(gnt_o), 64'h2);
        chk("pr_we_o", 64'(we_o), 64'h0);
        @(negedge clk);
        req_i = 2'b00; #1;
        chk("pr_rvalid", 64'(rvalid_o), 64'h2);
        chk("pr_rdata1", 64'(rdata_o[1]), 64'hFFFF3344);
        chk("pr_rdata0_zero", 64'(rdata_o[0]), 64'h0);

        // Reset pulse, then contention from both ports.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        req_i = 2'b11; we_i = 2'b00; addr_i[0] = 8'h10; addr_i[1] = 8'h20; #1;
        chk("ct0_gnt", 64'(gnt_o), 64'h1);
        chk("ct0_addr", 64'(addr_o), 64'h10);
        chk("ct0_rvalid", 64'(rvalid_o), 64'h0);
`ifndef SP_RAM_ARB_FIXED_PRIO_EN
        @(negedge clk); #1;
        chk("ct1_gnt", 64'(gnt_o), 64'h2);
        chk("ct1_addr", 64'(addr_o), 64'h20);
        chk("ct1_rvalid", 64'(rvalid_o), 64'h1);
        chk("ct1_rdata0", 64'(rdata_o[0]), 64'hDEADBEEF);
        @(negedge clk); #1;
        chk("ct2_gnt", 64'(gnt_o), 64'h1);
        chk("ct2_rvalid", 64'(rvalid_o), 64'h2);
        chk("ct2_rdata1", 64'(rdata_o[1]), 64'hFFFF3344);
        @(negedge clk); #1;
        chk("ct3_gnt", 64'(gnt_o), 64'h2);
        chk("ct3_rvalid", 64'(rvalid_o), 64'h1);
        @(negedge clk);
        req_i = 2'b00; #1;
        chk("ct4_rvalid", 64'(rvalid_o), 64'h2);
        chk("ct4_gnt", 64'(gnt_o), 64'h0);
`else
        @(negedge clk); #1;
        chk("fp1_gnt", 64'(gnt_o), 64'h1);
        chk("fp1_rvalid", 64'(rvalid_o), 64'h1);
        @(negedge clk); #1;
        chk("fp2_gnt", 64'(gnt_o), 64'h1);
        chk("fp2_rvalid", 64'(rvalid_o), 64'h1);
        @(negedge clk);
        req_i = 2'b00; #1;
        chk("fp3_rvalid", 64'(rvalid_o), 64'h1);
        chk("fp3_gnt", 64'(gnt_o), 64'h0);
`endif

        // Reset lands in the cycle port 0 is granted a read.
        @(negedge clk);
        req_i = 2'b01; we_i[0] = 1'b0; addr_i[0] = 8'h10; #1;
        chk("rm_gnt", 64'(gnt_o), 64'h1);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("rm_rvalid_in_rst", 64'(rvalid_o), 64'h0);
        @(negedge clk);
        rst = 1'b0; req_i = 2'b00; #1;
        chk("rm_rvalid_rel", 64'(rvalid_o), 64'h0);
        chk("rm_rdata0", 64'(rdata_o[0]), 64'h0);
        @(negedge clk); #1;
        chk("rm_rvalid_after", 64'(rvalid_o), 64'h0);
        @(negedge clk);
        req_i = 2'b11; #1;
        chk("rm_prio_gnt0", 64'(gnt_o), 64'h1);
        @(negedge clk); #1;
`ifndef SP_RAM_ARB_FIXED_PRIO_EN
        chk("rm_prio_gnt1", 64'(gnt_o), 64'h2);
`else
        chk("rm_prio_gnt1", 64'(gnt_o), 64'h1);
`endif
        chk("rm_rvalid_ct", 64'(rvalid_o), 64'h1);
        @(negedge clk);
        req_i = 2'b00; #1;
`ifndef SP_RAM_ARB_FIXED_PRIO_EN
        chk("rm_rvalid_ct2", 64'(rvalid_o), 64'h2);
`else
        chk("rm_rvalid_ct2", 64'(rvalid_o), 64'h1);
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
